// File: rtl/clint.sv
// Core-local interruptor: 64-bit mtime/mtimecmp and msip behind a two-state
// request/response slave, driving registered timer and software interrupt levels.
module clint #(
  parameter int unsigned RTC_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clint_valid,
  input  logic [31:0] clint_addr,
  input  logic [31:0] clint_wdata,
  input  logic [3:0]  clint_wstrb,
  output logic [31:0] clint_rdata,
  output logic        clint_ready,
  output logic        timer_irpt,
  output logic        soft_irpt
);

  localparam logic [15:0] DivLast   = 16'(RTC_DIV - 1);
  localparam logic [13:0] OffMsip   = 14'h0000;
  localparam logic [13:0] OffCmpLo  = 14'h1000;
  localparam logic [13:0] OffCmpHi  = 14'h1001;
  localparam logic [13:0] OffTimeLo = 14'h2FFE;
  localparam logic [13:0] OffTimeHi = 14'h2FFF;

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e      state_q;
  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, timer_q, soft_q;
  logic        tick, accept, wr;
  logic [13:0] off;
  logic        unused_addr;

  assign unused_addr = ^{clint_addr[31:16], clint_addr[1:0]};
  assign off    = clint_addr[15:2];
  assign accept = clint_valid && (state_q == StIdle);
  assign wr     = accept && (clint_wstrb != 4'b0000);
  assign tick   = (presc_q == DivLast);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    // A bus write to either mtime half overrides (and drops) a coincident tick.
    if (wr && off == OffTimeLo) mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], clint_wdata, clint_wstrb)};
    if (wr && off == OffTimeHi) mtime_d = {merge(mtime_q[63:32], clint_wdata, clint_wstrb), mtime_q[31:0]};
    if (wr && off == OffCmpLo) mtimecmp_d[31:0] = merge(mtimecmp_q[31:0], clint_wdata, clint_wstrb);
    if (wr && off == OffCmpHi) mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], clint_wdata, clint_wstrb);
    if (wr && off == OffMsip && clint_wstrb[0]) msip_d = clint_wdata[0];
  end

  always_comb begin
    rdata_d = 32'd0;
    case (off)
      OffMsip:   rdata_d = {31'd0, msip_q};
      OffCmpLo:  rdata_d = mtimecmp_q[31:0];
      OffCmpHi:  rdata_d = mtimecmp_q[63:32];
      OffTimeLo: rdata_d = mtime_q[31:0];
      OffTimeHi: rdata_d = mtime_q[63:32];
      default:   rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (clint_valid) begin
            state_q <= StResp;
            ready_q <= 1'b1;
            rdata_q <= rdata_d;
          end
        end
        StResp: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
          rdata_q <= 32'd0;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
          rdata_q <= 32'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= 16'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      timer_q    <= 1'b0;
      soft_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      timer_q    <= (mtime_q >= mtimecmp_q);
      soft_q     <= msip_q;
    end
  end

  assign clint_rdata = rdata_q;
  assign clint_ready = ready_q;
  assign timer_irpt  = timer_q;
  assign soft_irpt   = soft_q;

endmodule
